uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter that sits directly downstream of `RISC_V_Multi_Cycle`'s data bus, consuming processor stores and producing the serial `uart_tx_out` line. It is a peripheral alongside the GPIO port. It buffers bytes in a small FIFO and serialises them as 8N1 frames at a fixed, parameterised bit period. Software polls a status register to avoid overflow.

---
 rtl/uart_tx_mmio.sv | 136 +++++++++++++
 tb/tb_uart_tx_mmio.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a small byte FIFO and a polled status register.
module uart_tx_mmio #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        uart_tx_out
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   DEPTH     = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sh_q, sh_d;
    logic          tx_q, tx_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wp_q, rp_q;
    logic [PW:0]   cnt_q;
    logic          ov_q;
    logic          full, empty, push, pop, baud_done, ov_set, ov_clr, busy;
    logic [3:0]    cnt_f;
    logic          unused_wd;

    assign full      = cnt_q == DEPTH;
    assign empty     = cnt_q == '0;
    assign push      = we && addr == 4'h0 && !full;
    assign ov_set    = we && addr == 4'h0 && full;
    assign ov_clr    = we && addr == 4'h4 && wd[3];
    assign baud_done = baud_q == BAUD_LAST;
    assign busy      = state_q != IDLE;
    assign cnt_f     = 4'(cnt_q);
    assign unused_wd = ^wd[31:8];

    assign rd          = addr == 4'h4 ? {24'b0, cnt_f, ov_q, empty, full, busy} : 32'b0;
    assign uart_tx_out = tx_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= wd[7:0];
    end

    // A push is gated on the pre-edge full flag, so a same-edge pop cannot rescue it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            ov_q  <= 1'b0;
        end else begin
            wp_q  <= push ? wp_q + PW'(1) : wp_q;
            rp_q  <= pop ? rp_q + PW'(1) : rp_q;
            cnt_q <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
            ov_q  <= ov_set | (ov_q & ~ov_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_done ? '0 : baud_q + CW'(1);
        idx_d   = idx_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    sh_d    = mem_q[rp_q];
                    tx_d    = 1'b0;
                    idx_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_done) begin
                    tx_d    = sh_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_done) begin
                    if (idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        sh_d  = sh_q >> 1;
                        tx_d  = sh_q[1];
                    end
                end
            end
            STOP: begin
                // Chain straight into the next start bit when more data is queued.
                if (baud_done) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        sh_d    = mem_q[rp_q];
                        tx_d    = 1'b0;
                        idx_d   = '0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: directed bench for uart_tx_mmio with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_uart_tx_mmio;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  addr = 4'h0;
    logic [31:0] wd = 32'h0;
    logic [31:0] rd;
    logic        uart_tx_out;
    int          compared = 0;
    int          mismatched = 0;

    uart_tx_mmio #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .we(we),
        .addr(addr),
        .wd(wd),
        .rd(rd),
        .uart_tx_out(uart_tx_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        we = 1'b1;
        addr = a;
        wd = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    // Called at the negedge just after the start bit was driven; checks every cycle of the frame.
    task automatic frame(input logic [7:0] b, input string tag);
        logic e;
        addr = 4'h4;
        for (int i = 0; i < 10; i++) begin
            e = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
            for (int c = 0; c < 4; c++) begin
                #1;
                chk({tag, "_line"}, 32'(uart_tx_out), 32'(e));
                chk({tag, "_busy"}, 32'(rd[0]), 32'd1);
                @(negedge clk);
            end
        end
    endtask

    task automatic rx(output logic [7:0] b, input int idx0);
        int idx;
        int n;
        idx = idx0;
        b = '0;
        if (idx0 < 0) begin
            n = 0;
            while (uart_tx_out !== 1'b0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("rx_start_found", 32'(n < 200), 32'd1);
            idx = 0;
        end
        for (int k = 0; k < 8; k++) begin
            while (idx < 6 + 4 * k) begin
                @(negedge clk);
                idx++;
            end
            b[k] = uart_tx_out;
        end
        while (idx < 38) begin
            @(negedge clk);
            idx++;
        end
        chk("rx_stop", 32'(uart_tx_out), 32'd1);
    endtask

    initial begin
        logic [7:0] b;
        int lows;
        @(negedge clk);
        #1;
        chk("rst_line_held", 32'(uart_tx_out), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        addr = 4'h4;
        #1;
        chk("rst_line", 32'(uart_tx_out), 32'd1);
        chk("rst_status", rd, 32'h04);

        wr(4'h0, 32'hFFFF_FFA5);
        addr = 4'h4;
        #1;
        chk("single_line_pre", 32'(uart_tx_out), 32'd1);
        chk("single_status_pre", rd, 32'h10);
        @(negedge clk);
        frame(8'hA5, "single");
        #1;
        chk("single_status_post", rd, 32'h04);
        chk("single_line_post", 32'(uart_tx_out), 32'd1);

        wr(4'h0, 32'h55);
        addr = 4'h4;
        #1;
        chk("b2b_count1", rd, 32'h10);
        wr(4'h0, 32'h0F);
        addr = 4'h4;
        #1;
        chk("b2b_count1_busy", rd, 32'h11);
        frame(8'h55, "b2b_f1");
        #1;
        chk("b2b_count0_busy", rd, 32'h05);
        frame(8'h0F, "b2b_f2");
        #1;
        chk("b2b_status_post", rd, 32'h04);

        for (int i = 1; i <= 5; i++) wr(4'h0, 32'(i));
        addr = 4'h4;
        #1;
        chk("ovf_full", rd, 32'h43);
        wr(4'h0, 32'h06);
        addr = 4'h4;
        #1;
        chk("ovf_set", rd, 32'h4B);
        rx(b, 4);
        chk("ovf_byte1", 32'(b), 32'h01);
        wr(4'h4, 32'h8);
        #1;
        chk("ovf_clear", rd, 32'h43);
        for (int i = 2; i <= 5; i++) begin
            rx(b, -1);
            chk("ovf_byte", 32'(b), 32'(i));
        end
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (uart_tx_out !== 1'b1) lows++;
        end
        chk("ovf_no_sixth", 32'(lows), 32'd0);
        #1;
        chk("ovf_status_end", rd, 32'h04);

        wr(4'h0, 32'h00);
        wr(4'h0, 32'h00);
        for (int i = 0; i < 10; i++) @(negedge clk);
        #1;
        chk("midrst_in_data", 32'(uart_tx_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        addr = 4'h4;
        #1;
        chk("midrst_line", 32'(uart_tx_out), 32'd1);
        chk("midrst_status", rd, 32'h04);
        lows = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (uart_tx_out !== 1'b1) lows++;
        end
        chk("midrst_no_frames", 32'(lows), 32'd0);
        #1;
        chk("midrst_status_end", rd, 32'h04);

        wr(4'h8, 32'hFF);
        addr = 4'h0;
        #1;
        chk("decode_rd0", rd, 32'h0);
        addr = 4'hC;
        #1;
        chk("decode_rdC", rd, 32'h0);
        addr = 4'h8;
        #1;
        chk("decode_rd8", rd, 32'h0);
        addr = 4'h4;
        #1;
        chk("decode_status", rd, 32'h04);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("decode_line", 32'(uart_tx_out), 32'd1);
        chk("decode_status_late", rd, 32'h04);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
